// File: rtl/bsg_burst_addr_sequencer.sv
// Burst address sequencer: accepts (addr, len) commands and emits len+1
// consecutive beat addresses under consumer flow control, with abort and chaining.
module bsg_burst_addr_sequencer #(
   parameter int addr_width_p = 32,
   parameter int len_width_p  = 8
) (
   input  logic                    clk_i,
   input  logic                    reset_n_i,
   input  logic                    cmd_v_i,
   input  logic [addr_width_p-1:0] cmd_addr_i,
   input  logic [len_width_p-1:0]  cmd_len_i,
   output logic                    cmd_ready_o,
   output logic                    addr_v_o,
   output logic [addr_width_p-1:0] addr_o,
   output logic                    addr_last_o,
   input  logic                    addr_yumi_i,
   input  logic                    abort_i,
   output logic                    busy_o,
   output logic                    done_o
);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_e;

   state_e                  state_r, state_n_s;
   logic [addr_width_p-1:0] addr_r, addr_n_s;
   logic [len_width_p-1:0]  beat_r, beat_n_s;
   logic [len_width_p-1:0]  len_r, len_n_s;
   logic                    done_r, done_n_s;
   logic                    last_s;
   logic                    load_s;
   logic                    incr_s;

   // Next-state, counter control and handshake outputs.
   always_comb begin
      state_n_s   = state_r;
      done_n_s    = 1'b0;
      load_s      = 1'b0;
      incr_s      = 1'b0;
      last_s      = 1'b0;
      cmd_ready_o = 1'b0;
      addr_v_o    = 1'b0;
      busy_o      = 1'b0;
      case (state_r)
         IDLE: begin
            cmd_ready_o = 1'b1;
            if (cmd_v_i) begin
               load_s    = 1'b1;
               state_n_s = BURST;
            end else begin
               state_n_s = IDLE;
            end
         end
         BURST: begin
            addr_v_o    = 1'b1;
            busy_o      = 1'b1;
            last_s      = (beat_r == len_r);
            // Ready only on the consuming last beat so the next burst chains without a bubble.
            cmd_ready_o = last_s & addr_yumi_i & ~abort_i;
            if (abort_i) begin
               state_n_s = IDLE;
            end else if (addr_yumi_i && last_s) begin
               done_n_s = 1'b1;
               if (cmd_v_i) begin
                  load_s    = 1'b1;
                  state_n_s = BURST;
               end else begin
                  state_n_s = IDLE;
               end
            end else if (addr_yumi_i) begin
               incr_s = 1'b1;
            end else begin
               state_n_s = BURST;
            end
         end
         default: begin
            state_n_s = IDLE;
         end
      endcase
   end

   // Counter datapath: load on command acceptance, advance on a non-final beat.
   always_comb begin
      addr_n_s = addr_r;
      beat_n_s = beat_r;
      len_n_s  = len_r;
      if (load_s) begin
         addr_n_s = cmd_addr_i;
         beat_n_s = {len_width_p{1'b0}};
         len_n_s  = cmd_len_i;
      end else if (incr_s) begin
         addr_n_s = addr_r + {{(addr_width_p-1){1'b0}}, 1'b1};
         beat_n_s = beat_r + {{(len_width_p-1){1'b0}}, 1'b1};
      end else begin
         addr_n_s = addr_r;
         beat_n_s = beat_r;
      end
   end

   // State and counter registers with synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         state_r <= IDLE;
         addr_r  <= {addr_width_p{1'b0}};
         beat_r  <= {len_width_p{1'b0}};
         len_r   <= {len_width_p{1'b0}};
         done_r  <= 1'b0;
      end else begin
         state_r <= state_n_s;
         addr_r  <= addr_n_s;
         beat_r  <= beat_n_s;
         len_r   <= len_n_s;
         done_r  <= done_n_s;
      end
   end

   assign addr_o      = addr_r;
   assign addr_last_o = last_s;
   assign done_o      = done_r;

endmodule

// File: tb/tb_bsg_burst_addr_sequencer.sv
// Directed bench for bsg_burst_addr_sequencer: inputs change on the falling
// edge, outputs are checked 1ns later against hand-computed values.
module tb_bsg_burst_addr_sequencer;

   logic        clk_i = 1'b0;
   logic        reset_n_i;
   logic        cmd_v_i;
   logic [31:0] cmd_addr_i;
   logic [7:0]  cmd_len_i;
   logic        cmd_ready_o;
   logic        addr_v_o;
   logic [31:0] addr_o;
   logic        addr_last_o;
   logic        addr_yumi_i;
   logic        abort_i;
   logic        busy_o;
   logic        done_o;

   int checks   = 0;
   int failures = 0;

   bsg_burst_addr_sequencer #(.addr_width_p(32), .len_width_p(8)) dut (
      .clk_i       (clk_i),
      .reset_n_i   (reset_n_i),
      .cmd_v_i     (cmd_v_i),
      .cmd_addr_i  (cmd_addr_i),
      .cmd_len_i   (cmd_len_i),
      .cmd_ready_o (cmd_ready_o),
      .addr_v_o    (addr_v_o),
      .addr_o      (addr_o),
      .addr_last_o (addr_last_o),
      .addr_yumi_i (addr_yumi_i),
      .abort_i     (abort_i),
      .busy_o      (busy_o),
      .done_o      (done_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [31:0] a, input logic [7:0] l,
                        input logic y, input logic ab);
      cmd_v_i     = v;
      cmd_addr_i  = a;
      cmd_len_i   = l;
      addr_yumi_i = y;
      abort_i     = ab;
      #1;
   endtask

   task automatic next_cycle();
      @(negedge clk_i);
   endtask

   task automatic expect_beat(input string tag, input logic [31:0] a, input logic last,
                              input logic done);
      chk({tag, "_v"}, addr_v_o, 1'b1);
      chk({tag, "_busy"}, busy_o, 1'b1);
      chk({tag, "_addr"}, addr_o, a);
      chk({tag, "_last"}, addr_last_o, last);
      chk({tag, "_done"}, done_o, done);
   endtask

   task automatic expect_idle(input string tag, input logic done);
      chk({tag, "_v"}, addr_v_o, 1'b0);
      chk({tag, "_busy"}, busy_o, 1'b0);
      chk({tag, "_last"}, addr_last_o, 1'b0);
      chk({tag, "_rdy"}, cmd_ready_o, 1'b1);
      chk({tag, "_done"}, done_o, done);
   endtask

   initial begin
      int n;
      logic seen_last;
      logic [31:0] last_addr;

      // Reset with inputs active to confirm reset dominates
      reset_n_i = 1'b0;
      drive(1'b1, 32'h0000_0abc, 8'd5, 1'b1, 1'b0);
      next_cycle();
      next_cycle();
      drive(1'b0, 32'h0, 8'd0, 1'b0, 1'b0);
      expect_idle("rst", 1'b0);
      chk("rst_addr", addr_o, 32'h0);
      reset_n_i = 1'b1;
      next_cycle();
      expect_idle("post_rst", 1'b0);

      // addr 0x100, len 3, yumi every cycle
      drive(1'b1, 32'h100, 8'd3, 1'b0, 1'b0);
      chk("b1_accept", cmd_ready_o, 1'b1);
      next_cycle();
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 32'h0, 8'd0, 1'b1, 1'b0);
         expect_beat("b1", 32'h100 + 32'(i), (i == 3), 1'b0);
         chk("b1_rdy", cmd_ready_o, (i == 3));
         next_cycle();
      end
      drive(1'b0, 32'h0, 8'd0, 1'b0, 1'b0);
      expect_idle("b1_end", 1'b1);
      next_cycle();
      chk("b1_done_once", done_o, 1'b0);

      // Single-beat burst
      drive(1'b1, 32'h40, 8'd0, 1'b0, 1'b0);
      next_cycle();
      drive(1'b0, 32'h0, 8'd0, 1'b1, 1'b0);
      expect_beat("one", 32'h40, 1'b1, 1'b0);
      next_cycle();
      drive(1'b0, 32'h0, 8'd0, 1'b0, 1'b0);
      expect_idle("one_end", 1'b1);
      next_cycle();

      // Stall for five cycles mid-burst
      drive(1'b1, 32'h300, 8'd3, 1'b0, 1'b0);
      next_cycle();
      drive(1'b0, 32'h0, 8'd0, 1'b1, 1'b0);
      expect_beat("st0", 32'h300, 1'b0, 1'b0);
      next_cycle();
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 32'h0, 8'd0, 1'b0, 1'b0);
         expect_beat("stall", 32'h301, 1'b0, 1'b0);
         chk("stall_beat", dut.beat_r, 8'd1);
         next_cycle();
      end
      for (int i = 1; i < 4; i++) begin
         drive(1'b0, 32'h0, 8'd0, 1'b1, 1'b0);
         expect_beat("st", 32'h300 + 32'(i), (i == 3), 1'b0);
         next_cycle();
      end
      drive(1'b0, 32'h0, 8'd0, 1'b0, 1'b0);
      expect_idle("st_end", 1'b1);
      next_cycle();

      // Chained command during the last beat: no bubble
      drive(1'b1, 32'h500, 8'd1, 1'b0, 1'b0);
      next_cycle();
      drive(1'b0, 32'h0, 8'd0, 1'b1, 1'b0);
      expect_beat("ch0", 32'h500, 1'b0, 1'b0);
      next_cycle();
      drive(1'b1, 32'h200, 8'd1, 1'b1, 1'b0);
      expect_beat("ch1", 32'h501, 1'b1, 1'b0);
      chk("ch_accept", cmd_ready_o, 1'b1);
      next_cycle();
      drive(1'b0, 32'h0, 8'd0, 1'b1, 1'b0);
      expect_beat("ch2", 32'h200, 1'b0, 1'b1);
      next_cycle();
      expect_beat("ch3", 32'h201, 1'b1, 1'b0);
      next_cycle();
      drive(1'b0, 32'h0, 8'd0, 1'b0, 1'b0);
      expect_idle("ch_end", 1'b1);
      next_cycle();

      // Address wrap at the top of the space
      drive(1'b1, 32'hffff_fffe, 8'd2, 1'b0, 1'b0);
      next_cycle();
      drive(1'b0, 32'h0, 8'd0, 1'b1, 1'b0);
      expect_beat("wr0", 32'hffff_fffe, 1'b0, 1'b0);
      next_cycle();
      expect_beat("wr1", 32'hffff_ffff, 1'b0, 1'b0);
      next_cycle();
      expect_beat("wr2", 32'h0, 1'b1, 1'b0);
      next_cycle();
      drive(1'b0, 32'h0, 8'd0, 1'b0, 1'b0);
      expect_idle("wr_end", 1'b1);
      next_cycle();

      // Abort on beat 2 with a concurrent command
      drive(1'b1, 32'h700, 8'd7, 1'b0, 1'b0);
      next_cycle();
      drive(1'b0, 32'h0, 8'd0, 1'b1, 1'b0);
      expect_beat("ab0", 32'h700, 1'b0, 1'b0);
      next_cycle();
      expect_beat("ab1", 32'h701, 1'b0, 1'b0);
      next_cycle();
      drive(1'b1, 32'h900, 8'd0, 1'b1, 1'b1);
      expect_beat("ab2", 32'h702, 1'b0, 1'b0);
      chk("ab_no_accept", cmd_ready_o, 1'b0);
      next_cycle();
      // Abort still high in IDLE: ignored, command accepted
      drive(1'b1, 32'h900, 8'd0, 1'b0, 1'b1);
      expect_idle("ab_idle", 1'b0);
      next_cycle();
      drive(1'b0, 32'h0, 8'd0, 1'b1, 1'b0);
      expect_beat("ab_new", 32'h900, 1'b1, 1'b0);
      next_cycle();
      drive(1'b0, 32'h0, 8'd0, 1'b0, 1'b0);
      expect_idle("ab_new_end", 1'b1);
      next_cycle();

      // Maximum length: 256 beats
      drive(1'b1, 32'h0, 8'd255, 1'b0, 1'b0);
      next_cycle();
      n = 0;
      seen_last = 1'b0;
      last_addr = 32'h0;
      drive(1'b0, 32'h0, 8'd0, 1'b1, 1'b0);
      while (!seen_last && n < 300) begin
         if (addr_v_o) n++;
         if (addr_last_o) begin
            seen_last = 1'b1;
            last_addr = addr_o;
         end
         next_cycle();
         #1;
      end
      chk("max_seen_last", seen_last, 1'b1);
      chk("max_beats", n, 256);
      chk("max_last_addr", last_addr, 32'hff);
      drive(1'b0, 32'h0, 8'd0, 1'b0, 1'b0);
      expect_idle("max_end", 1'b1);
      next_cycle();

      // Reset mid-burst discards without done
      drive(1'b1, 32'h10, 8'd3, 1'b0, 1'b0);
      next_cycle();
      drive(1'b0, 32'h0, 8'd0, 1'b1, 1'b0);
      expect_beat("rm0", 32'h10, 1'b0, 1'b0);
      reset_n_i = 1'b0;
      next_cycle();
      reset_n_i = 1'b1;
      drive(1'b0, 32'h0, 8'd0, 1'b0, 1'b0);
      expect_idle("rm_end", 1'b0);
      chk("rm_addr", addr_o, 32'h0);
      next_cycle();
      chk("rm_no_done", done_o, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
